// File: rtl/vrased_reset_ctrl.sv
// VRASED violation-to-reset controller: stretches monitor violations into a core reset request,
// records sticky and first causes, counts episodes and waits for the core to refetch the reset vector.
module vrased_reset_ctrl #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned PC_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  viol,
    input  logic [15:0] pc,
    input  logic        cause_clr,
    output logic        sys_rst,
    output logic        busy,
    output logic [5:0]  cause,
    output logic [5:0]  first_cause,
    output logic [7:0]  viol_cnt
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(PC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_PC = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        sys_rst_q, sys_rst_d;
    logic        busy_q, busy_d;
    logic [5:0]  cause_q, cause_d;
    logic [5:0]  first_cause_q, first_cause_d;
    logic [7:0]  viol_cnt_q, viol_cnt_d;
    logic        hit;
    logic        new_episode;

    assign hit = |viol;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        to_cnt_d      = to_cnt_q;
        cause_d       = cause_q;
        first_cause_d = first_cause_q;
        viol_cnt_d    = viol_cnt_q;
        new_episode   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d     = ASSERT;
                    rst_cnt_d   = RST_LAST;
                    new_episode = 1'b1;
                end else if (cause_clr) begin
                    cause_d       = '0;
                    first_cause_d = '0;
                end
            end
            ASSERT: begin
                if (hit) begin
                    rst_cnt_d = RST_LAST;
                end else if (rst_cnt_q == 8'd0) begin
                    state_d  = WAIT_PC;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q - 8'd1;
                end
            end
            WAIT_PC: begin
                if (hit) begin
                    state_d     = ASSERT;
                    rst_cnt_d   = RST_LAST;
                    new_episode = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = ASSERT;
                    rst_cnt_d = RST_LAST;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A violation is always recorded, so it overrides any clear taken above.
        if (hit) begin
            cause_d = cause_q | viol;
        end
        if (new_episode) begin
            if (viol_cnt_q != 8'hFF) begin
                viol_cnt_d = viol_cnt_q + 8'd1;
            end
            if (first_cause_q == 6'd0) begin
                first_cause_d = viol;
            end
        end

        // Outputs are registered from the next state so they line up with the state flop.
        sys_rst_d = (state_d == ASSERT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            to_cnt_q      <= '0;
            sys_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            cause_q       <= '0;
            first_cause_q <= '0;
            viol_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            to_cnt_q      <= to_cnt_d;
            sys_rst_q     <= sys_rst_d;
            busy_q        <= busy_d;
            cause_q       <= cause_d;
            first_cause_q <= first_cause_d;
            viol_cnt_q    <= viol_cnt_d;
        end
    end

    assign sys_rst     = sys_rst_q;
    assign busy        = busy_q;
    assign cause       = cause_q;
    assign first_cause = first_cause_q;
    assign viol_cnt    = viol_cnt_q;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed bench for vrased_reset_ctrl with hand-computed expectations.
module tb_vrased_reset_ctrl;

    logic        clk;
    logic        reset_n;
    logic [5:0]  viol;
    logic [15:0] pc;
    logic        cause_clr;
    logic        sys_rst;
    logic        busy;
    logic [5:0]  cause;
    logic [5:0]  first_cause;
    logic [7:0]  viol_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    vrased_reset_ctrl #(
        .RESET_HANDLER(16'h0000),
        .RST_CYCLES   (8),
        .PC_TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .viol       (viol),
        .pc         (pc),
        .cause_clr  (cause_clr),
        .sys_rst    (sys_rst),
        .busy       (busy),
        .cause      (cause),
        .first_cause(first_cause),
        .viol_cnt   (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns so registered outputs are stable.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        viol = '0; pc = 16'h1234; cause_clr = 1'b0;
        #12;
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic check_all(input string tag, input logic sr, input logic bz,
                             input logic [5:0] c, input logic [5:0] fc, input logic [7:0] vc);
        check({tag, ".sys_rst"}, 32'(sys_rst), 32'(sr));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
        check({tag, ".cause"}, 32'(cause), 32'(c));
        check({tag, ".first_cause"}, 32'(first_cause), 32'(fc));
        check({tag, ".viol_cnt"}, 32'(viol_cnt), 32'(vc));
    endtask

    initial begin
        int unsigned hi_cnt;
        reset_n = 1'b1; viol = '0; pc = 16'h1234; cause_clr = 1'b0;

        // 1: reset state and quiet idle
        do_reset();
        check_all("rst", 1'b0, 1'b0, 6'h00, 6'h00, 8'h00);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sys_rst) hi_cnt++;
        end
        check("idle_quiet", 32'(hi_cnt), 32'd0);

        // 2: single hit, 8-cycle reset, release by pc
        viol = 6'h02;
        step(1);
        viol = '0;
        check_all("hit1", 1'b1, 1'b1, 6'h02, 6'h02, 8'h01);
        step(7);
        check("hit1.last_high", 32'(sys_rst), 32'd1);
        step(1);
        check("hit1.low", 32'(sys_rst), 32'd0);
        check("hit1.wait_busy", 32'(busy), 32'd1);
        step(3);
        pc = 16'h0000;
        step(1);
        check("hit1.release", 32'(busy), 32'd0);
        pc = 16'h1234;

        // 3: extension by a second hit inside ASSERT
        do_reset();
        viol = 6'h01;
        step(1);
        viol = '0;
        step(4);
        viol = 6'h10;
        step(1);
        viol = '0;
        step(7);
        check("ext.high7", 32'(sys_rst), 32'd1);
        step(1);
        check_all("ext.end", 1'b0, 1'b1, 6'h11, 6'h01, 8'h01);

        // 4: pc timeout re-asserts without counting, then WAIT_PC hit beats pc match
        do_reset();
        viol = 6'h08;
        step(1);
        viol = '0;
        step(8);
        check("to.wait", 32'(sys_rst), 32'd0);
        step(15);
        check("to.still_wait", 32'(sys_rst), 32'd0);
        step(1);
        check_all("to.reassert", 1'b1, 1'b1, 6'h08, 6'h08, 8'h01);
        cause_clr = 1'b1;
        step(7);
        cause_clr = 1'b0;
        check("to.high7", 32'(sys_rst), 32'd1);
        check("to.clr_ignored", 32'(cause), 32'h08);
        step(1);
        check("to.low", 32'(sys_rst), 32'd0);
        viol = 6'h04; pc = 16'h0000;
        step(1);
        viol = '0;
        check_all("wait_hit", 1'b1, 1'b1, 6'h0C, 6'h08, 8'h02);
        step(9);
        check("wait_hit.release", 32'(busy), 32'd0);

        // 5: clear loses to a simultaneous hit, then clears alone
        do_reset();
        viol = 6'h20; cause_clr = 1'b1;
        step(1);
        viol = '0; cause_clr = 1'b0; pc = 16'h0000;
        check_all("clr_hit", 1'b1, 1'b1, 6'h20, 6'h20, 8'h01);
        step(9);
        check("clr_hit.idle", 32'(busy), 32'd0);
        cause_clr = 1'b1;
        step(1);
        cause_clr = 1'b0;
        check_all("clr_alone", 1'b0, 1'b0, 6'h00, 6'h00, 8'h01);

        // 6: saturation after 300 episodes, then async reset mid-ASSERT
        do_reset();
        pc = 16'h0000;
        for (int e = 1; e <= 300; e++) begin
            viol = 6'h01;
            step(1);
            viol = '0;
            step(9);
            if (e == 254) check("sat.254", 32'(viol_cnt), 32'hFE);
        end
        check("sat.ff", 32'(viol_cnt), 32'hFF);
        check("sat.idle", 32'(busy), 32'd0);
        viol = 6'h02;
        step(1);
        viol = '0;
        check("sat.hold", 32'(viol_cnt), 32'hFF);
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 6'h00, 6'h00, 8'h00);
        #10;
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
